// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: branch function codes,
// pc_mux_select values, instruction field widths and the RUN/HALT state type.
package pc_seq_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned IINDEX_W = 26;

    localparam logic [3:0] BF_BEQ  = 4'd0;
    localparam logic [3:0] BF_BNE  = 4'd1;
    localparam logic [3:0] BF_BLEZ = 4'd2;
    localparam logic [3:0] BF_BGTZ = 4'd3;
    localparam logic [3:0] BF_BLTZ = 4'd4;
    localparam logic [3:0] BF_BGEZ = 4'd5;

    localparam logic [1:0] PCSEL_JR  = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_J   = 2'b10;
    localparam logic [1:0] PCSEL_SEQ = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pc_branch_cond.sv
// Branch condition evaluator: signed compares of rs against rt or zero,
// selected by the branch function code. Unknown codes never take.
module pc_branch_cond
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      bf_i,
    output logic            taken_o
);

    logic a_neg;
    logic a_zero;

    // Sign bit and zero test avoid signed/unsigned literal mixing in compares
    assign a_neg  = a_i[XLEN-1];
    assign a_zero = (a_i == '0);

    always_comb begin
        taken_o = 1'b0;
        case (bf_i)
            BF_BEQ:  taken_o = (a_i == b_i);
            BF_BNE:  taken_o = (a_i != b_i);
            BF_BLEZ: taken_o = a_neg || a_zero;
            BF_BGTZ: taken_o = !a_neg && !a_zero;
            BF_BLTZ: taken_o = a_neg;
            BF_BGEZ: taken_o = !a_neg;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with RUN/HALT control, stall and resume handling.
// Define BRANCH_DELAY_SLOT_EN to defer taken transfers by one delay-slot instruction.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               stall,
    input  logic               resume,
    input  logic [XLEN-1:0]    a_gpr,
    input  logic [XLEN-1:0]    b_gpr,
    input  logic [3:0]         bf,
    input  logic [1:0]         pc_mux_select,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    next_pc,
    output logic [XLEN-1:0]    link_addr,
    output logic               halted,
    output logic               br_taken,
    output logic               misalign
);

    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            br_q, br_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] incr, br_tgt, j_tgt, jr_tgt, xfer_tgt;
    logic            cond_taken, xfer, xfer_mis;
    logic            advance, is_halt_word;

`ifdef BRANCH_DELAY_SLOT_EN
    logic            pend_vld_q, pend_vld_d;
    logic            pend_mis_q, pend_mis_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
`endif

    pc_branch_cond #(.XLEN(XLEN)) u_cond (
        .a_i     (a_gpr),
        .b_i     (b_gpr),
        .bf_i    (bf),
        .taken_o (cond_taken)
    );

    assign incr         = pc_q + XLEN'(4);
    assign br_tgt       = incr + {{(XLEN-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
    assign j_tgt        = {incr[XLEN-1:28], instr[IINDEX_W-1:0], 2'b00};
    assign jr_tgt       = {a_gpr[XLEN-1:2], 2'b00};
    assign advance      = (state_q == RUN) && instr_valid && !stall;
    assign is_halt_word = (instr == HALT_WORD);

    // Control-transfer decode for the instruction currently presented
    always_comb begin
        xfer     = 1'b0;
        xfer_tgt = incr;
        xfer_mis = 1'b0;
        case (pc_mux_select)
            PCSEL_BR: begin
                xfer     = cond_taken;
                xfer_tgt = br_tgt;
            end
            PCSEL_J: begin
                xfer     = 1'b1;
                xfer_tgt = j_tgt;
            end
            PCSEL_JR: begin
                xfer     = 1'b1;
                xfer_tgt = jr_tgt;
                xfer_mis = (a_gpr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Value pc takes on the next advance (or resume when halted); a halt word holds pc
    always_comb begin
        next_pc = incr;
        if ((state_q == RUN) && is_halt_word) begin
            next_pc = pc_q;
        end
`ifdef BRANCH_DELAY_SLOT_EN
        else if (pend_vld_q) begin
            next_pc = pend_tgt_q;
        end
`else
        else if ((state_q == RUN) && xfer) begin
            next_pc = xfer_tgt;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        br_d    = 1'b0;
        mis_d   = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        pend_mis_d = pend_mis_q;
`endif
        case (state_q)
            RUN: begin
                if (advance) begin
                    pc_d = next_pc;
                    if (is_halt_word) begin
                        state_d = HALT;
                    end
`ifdef BRANCH_DELAY_SLOT_EN
                    // Delay-slot instruction's own control is ignored when a target is pending
                    else if (pend_vld_q) begin
                        br_d       = 1'b1;
                        mis_d      = pend_mis_q;
                        pend_vld_d = 1'b0;
                    end
                    else if (xfer) begin
                        pend_vld_d = 1'b1;
                        pend_tgt_d = xfer_tgt;
                        pend_mis_d = xfer_mis;
                    end
`else
                    else begin
                        br_d  = xfer;
                        mis_d = xfer_mis;
                    end
`endif
                end
            end
            HALT: begin
                // Resume is a single-cycle pulse, so it is honoured regardless of stall
                if (resume) begin
                    state_d = RUN;
                    pc_d    = next_pc;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (pend_vld_q) begin
                        br_d       = 1'b1;
                        mis_d      = pend_mis_q;
                        pend_vld_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            br_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_mis_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_mis_q <= pend_mis_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign link_addr = pc_q + XLEN'(8);
`else
    assign link_addr = pc_q + XLEN'(4);
`endif

    assign pc       = pc_q;
    assign halted   = (state_q == HALT);
    assign br_taken = br_q;
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic, checked
// against a transaction-level PC model (follows BRANCH_DELAY_SLOT_EN when defined).
`timescale 1ns/1ps
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0040;
    localparam logic [31:0] HW   = 32'h0000_000D;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        v;
        logic        st;
        logic        res;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  bf;
        logic [1:0]  sel;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        bit          halt;
        bit          pv;
        logic [31:0] pt;
        bit          pm;
        bit          br;
        bit          mis;
    } mstate_t;

    typedef struct {
        logic [31:0] pc;
        bit          halt;
        bit          br;
        bit          mis;
    } exp_reg_t;

    typedef struct {
        bit          chk;
        logic [31:0] next_pc;
        logic [31:0] link;
    } exp_comb_t;

    logic            clk;
    logic            rst;
    logic [31:0]     instr;
    logic            instr_valid, stall, resume;
    logic [XLEN-1:0] a_gpr, b_gpr;
    logic [3:0]      bf;
    logic [1:0]      pc_mux_select;
    logic [XLEN-1:0] pc, next_pc, link_addr;
    logic            halted, br_taken, misalign;

    pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .HALT_WORD(HW)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .resume        (resume),
        .a_gpr         (a_gpr),
        .b_gpr         (b_gpr),
        .bf            (bf),
        .pc_mux_select (pc_mux_select),
        .pc            (pc),
        .next_pc       (next_pc),
        .link_addr     (link_addr),
        .halted        (halted),
        .br_taken      (br_taken),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_reg_t  reg_q[$];
    exp_comb_t comb_q[$];
    mstate_t   m;
    bit        m_init = 1'b0;
    int        n_checks = 0;
    int        n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Where a control instruction sends the PC, straight from the ISA description
    function automatic void target(input stim_t s, input logic [31:0] cur,
                                   output bit tk, output logic [31:0] tgt, output bit mis);
        logic [31:0] seq;
        longint      sa;
        int          imm;
        seq = cur + 32'd4;
        sa  = longint'($signed(s.a));
        imm = int'($signed(s.instr[15:0]));
        tk  = 1'b0;
        tgt = seq;
        mis = 1'b0;
        case (s.sel)
            PCSEL_BR: begin
                case (s.bf)
                    BF_BEQ:  tk = (s.a == s.b);
                    BF_BNE:  tk = (s.a != s.b);
                    BF_BLEZ: tk = (sa <= 0);
                    BF_BGTZ: tk = (sa > 0);
                    BF_BLTZ: tk = (sa < 0);
                    BF_BGEZ: tk = (sa >= 0);
                    default: tk = 1'b0;
                endcase
                tgt = seq + 32'(imm * 4);
            end
            PCSEL_J: begin
                tk  = 1'b1;
                tgt = (seq & 32'hF000_0000) | (32'(s.instr[25:0]) << 2);
            end
            PCSEL_JR: begin
                tk  = 1'b1;
                tgt = s.a & ~32'h3;
                mis = (s.a % 4) != 0;
            end
            default: ;
        endcase
    endfunction

    function automatic mstate_t step(input mstate_t cur, input stim_t s);
        mstate_t     r;
        bit          tk, mis;
        logic [31:0] tgt;
        r     = cur;
        r.br  = 1'b0;
        r.mis = 1'b0;
        if (s.rst) begin
            r.pc = RV; r.halt = 1'b0; r.pv = 1'b0;
            return r;
        end
        if (r.halt) begin
            if (s.res) begin
                r.halt = 1'b0;
                if (r.pv) begin r.pc = r.pt; r.pv = 1'b0; r.br = 1'b1; r.mis = r.pm; end
                else r.pc = r.pc + 32'd4;
            end
            return r;
        end
        if (!s.v || s.st) return r;
        if (s.instr == HW) begin
            r.halt = 1'b1;
            return r;
        end
        if (r.pv) begin
            r.pc = r.pt; r.pv = 1'b0; r.br = 1'b1; r.mis = r.pm;
            return r;
        end
        target(s, r.pc, tk, tgt, mis);
        if (!tk) r.pc = r.pc + 32'd4;
        else if (DS) begin r.pv = 1'b1; r.pt = tgt; r.pm = mis; r.pc = r.pc + 32'd4; end
        else begin r.pc = tgt; r.br = 1'b1; r.mis = mis; end
        return r;
    endfunction

    // Drive one cycle on the falling edge and queue what the DUT must show
    task automatic drive(input stim_t s);
        stim_t     hs;
        exp_comb_t ec;
        mstate_t   hyp;
        @(negedge clk);
        rst = s.rst; instr = s.instr; instr_valid = s.v; stall = s.st; resume = s.res;
        a_gpr = s.a; b_gpr = s.b; bf = s.bf; pc_mux_select = s.sel;
        hs = s; hs.rst = 1'b0; hs.v = 1'b1; hs.st = 1'b0; hs.res = 1'b1;
        hyp        = step(m, hs);
        ec.chk     = m_init;
        ec.next_pc = hyp.pc;
        ec.link    = m.pc + (DS ? 32'd8 : 32'd4);
        comb_q.push_back(ec);
        m = step(m, s);
        if (s.rst) m_init = 1'b1;
        reg_q.push_back('{pc: m.pc, halt: m.halt, br: m.br, mis: m.mis});
    endtask

    initial begin : reg_monitor
        exp_reg_t er;
        forever begin
            @(posedge clk); #1;
            if (reg_q.size() != 0) begin
                er = reg_q.pop_front();
                check("pc", pc, er.pc);
                check("halted", 32'(halted), 32'(er.halt));
                check("br_taken", 32'(br_taken), 32'(er.br));
                check("misalign", 32'(misalign), 32'(er.mis));
            end
        end
    end

    initial begin : comb_monitor
        exp_comb_t ec;
        forever begin
            @(negedge clk); #1;
            if (comb_q.size() != 0) begin
                ec = comb_q.pop_front();
                if (ec.chk) begin
                    check("next_pc", next_pc, ec.next_pc);
                    check("link_addr", link_addr, ec.link);
                end
            end
        end
    end

    function automatic stim_t mk(input logic [1:0] sel, input logic [31:0] ins,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        stim_t s;
        s.rst = 1'b0; s.instr = ins; s.v = 1'b1; s.st = 1'b0; s.res = 1'b0;
        s.a = a; s.b = b; s.bf = f; s.sel = sel;
        return s;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'($urandom_range(0, 9));
            2:       return -32'($urandom_range(1, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.sel   = 2'($urandom_range(0, 3));
        s.bf    = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 7));
        s.a     = rnd_word();
        s.b     = ($urandom_range(0, 2) == 0) ? s.a : rnd_word();
        s.instr = $urandom;
        if (s.instr == HW) s.instr = 32'h1234_5678;
        if ($urandom_range(0, 39) == 0) s.instr = HW;
        s.v     = ($urandom_range(0, 9) < 8);
        s.st    = ($urandom_range(0, 9) < 2);
        s.res   = ($urandom_range(0, 15) == 0);
        s.rst   = ($urandom_range(0, 199) == 0);
        return s;
    endfunction

    task automatic seq_adv(input int n);
        for (int i = 0; i < n; i++) drive(mk(PCSEL_SEQ, 32'h2000_0000, 32'h0, 32'h0, BF_BEQ));
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        drive(mk(PCSEL_JR, 32'h0400_0000, addr, 32'h0, BF_BEQ));
        if (DS) seq_adv(1);
    endtask

    initial begin : driver
        stim_t s;
        rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; resume = 1'b0;
        a_gpr = '0; b_gpr = '0; bf = 4'h0; pc_mux_select = PCSEL_SEQ;
        m = '{pc: 32'h0, halt: 1'b0, pv: 1'b0, pt: 32'h0, pm: 1'b0, br: 1'b0, mis: 1'b0};

        // Reset then three sequential fetches
        s = mk(PCSEL_SEQ, 32'h0, 32'h0, 32'h0, BF_BEQ); s.rst = 1'b1; s.v = 1'b0;
        drive(s); drive(s);
        seq_adv(3);

        // Backward-to-self BEQ, then not-taken BNE on equal operands
        goto_pc(32'h0000_0100);
        drive(mk(PCSEL_BR, 32'h1000_FFFF, 32'd5, 32'd5, BF_BEQ));
        if (DS) seq_adv(1);
        drive(mk(PCSEL_BR, 32'h1400_FFFF, 32'd5, 32'd5, BF_BNE));

        // J within region, misaligned JR
        goto_pc(32'h1000_0010);
        drive(mk(PCSEL_J, 32'h0800_0040, 32'h0, 32'h0, BF_BEQ));
        if (DS) seq_adv(1);
        drive(mk(PCSEL_JR, 32'h0000_0008, 32'h0000_0203, 32'h0, BF_BEQ));
        seq_adv(2);

        // Halt for 10 cycles (halt word beats a J select), then resume
        goto_pc(32'h0000_0020);
        drive(mk(PCSEL_J, HW, 32'h0, 32'h0, BF_BEQ));
        for (int i = 0; i < 10; i++) begin
            s = mk(PCSEL_J, 32'h0800_0100, 32'h0, 32'h0, BF_BEQ);
            s.v = 1'($urandom_range(0, 1));
            drive(s);
        end
        s = mk(PCSEL_SEQ, 32'h0, 32'h0, 32'h0, BF_BEQ); s.v = 1'b0; s.res = 1'b1;
        drive(s);
        drive(s);

        // Stalled taken branch commits on first unstalled cycle
        goto_pc(32'h0000_0300);
        s = mk(PCSEL_BR, 32'h1000_0010, 32'h7, 32'h7, BF_BEQ); s.st = 1'b1;
        drive(s); drive(s); drive(s);
        s.st = 1'b0;
        drive(s);
        seq_adv(2);

        // Taken BEQ at 0x40 with imm=4, followed by its slot
        goto_pc(32'h0000_0040);
        drive(mk(PCSEL_BR, 32'h1000_0004, 32'h3, 32'h3, BF_BEQ));
        seq_adv(2);

        // Halt right after a JR (delay slot when enabled), then resume
        goto_pc(32'h0000_0200);
        drive(mk(PCSEL_JR, 32'h0, 32'h0000_0501, 32'h0, BF_BEQ));
        drive(mk(PCSEL_SEQ, HW, 32'h0, 32'h0, BF_BEQ));
        seq_adv(2);
        s = mk(PCSEL_SEQ, 32'h0, 32'h0, 32'h0, BF_BEQ); s.res = 1'b1; s.v = 1'b0;
        drive(s);
        seq_adv(2);

        // Reset and resume together while halted
        drive(mk(PCSEL_SEQ, HW, 32'h0, 32'h0, BF_BEQ));
        s = mk(PCSEL_SEQ, 32'h0, 32'h0, 32'h0, BF_BEQ); s.rst = 1'b1; s.res = 1'b1;
        drive(s);
        seq_adv(2);

        for (int i = 0; i < 3000; i++) drive(rnd_stim());

        s = mk(PCSEL_SEQ, 32'h0, 32'h0, 32'h0, BF_BEQ); s.v = 1'b0;
        drive(s);
        @(posedge clk); #3;
        @(posedge clk); #3;
        if (reg_q.size() != 0 || comb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", reg_q.size(), comb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
